// File: rtl/fir_pkg.sv
// Shared types, widths and arithmetic helpers for the serial FIR MAC datapath.
package fir_pkg;

  // Widths are sized for the largest supported bank; smaller banks simply leave headroom.
  localparam int unsigned MAX_TAPS_LIM = 16;
  localparam int unsigned TAP_IDX_W    = $clog2(MAX_TAPS_LIM);
  localparam int unsigned CNT_W        = TAP_IDX_W + 1;
  localparam int unsigned ACC_W        = 64 + TAP_IDX_W;

  localparam logic signed [ACC_W-1:0] ACC_SAT_HI = ACC_W'(64'sh0000_0000_7FFF_FFFF);
  localparam logic signed [ACC_W-1:0] ACC_SAT_LO = ACC_W'(64'shFFFF_FFFF_8000_0000);

  typedef enum logic [1:0] {
    S_LOAD,
    S_READY,
    S_MAC,
    S_OUT
  } state_t;

  // Clamp a wide signed accumulator into the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] acc);
    if (acc > ACC_SAT_HI) return 32'h7FFF_FFFF;
    if (acc < ACC_SAT_LO) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  // Effective tap count: zero means one tap, anything above the bank depth clamps to it.
  function automatic logic [CNT_W-1:0] eff_taps(input logic [31:0] tap_count,
                                                input int unsigned max_taps);
    if (tap_count == 32'd0) return CNT_W'(1);
    if (tap_count > max_taps) return CNT_W'(max_taps);
    return CNT_W'(tap_count);
  endfunction

endpackage

// File: rtl/fir_mac_datapath_coeff_bank.sv
// Coefficient register file: synchronous write port, asynchronous read port.
module fir_coeff_bank #(
  parameter int unsigned MAX_TAPS = 16,
  parameter int unsigned IDX_W    = $clog2(MAX_TAPS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MAX_TAPS];

  // Contents are only meaningful below the latched tap count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_datapath.sv
// FIR datapath: coefficient bank, sample delay line and a one-tap-per-cycle serial MAC.
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int unsigned MAX_TAPS  = MAX_TAPS_LIM,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] tap_count,
  input  logic [31:0] coeff_data,
  input  logic        coeff_data_valid,
  input  logic [31:0] x_data,
  input  logic        x_data_valid,
  input  logic        compute,
  output logic        coefficient_loading_complete,
  output logic        output_data_valid,
  output logic [31:0] output_data,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned IDX_W = $clog2(MAX_TAPS);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         wptr_q, wptr_d;
  logic [IDX_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [31:0]       x_q [MAX_TAPS];
  logic signed [31:0]       x_d [MAX_TAPS];
  logic                     complete_q, complete_d;
  logic                     valid_q, valid_d;
  logic [31:0]              data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic                     coeff_we;
  logic [IDX_W-1:0]         coeff_waddr;
  logic [31:0]              coeff_rd;
  logic [31:0]              x_k;
  logic signed [63:0]       prod;
  logic [CNT_W-1:0]         n_req;
  logic [CNT_W-1:0]         n_load;

  fir_coeff_bank #(
    .MAX_TAPS (MAX_TAPS),
    .IDX_W    (IDX_W)
  ) u_coeff_bank (
    .clk   (clk),
    .we    (coeff_we),
    .waddr (coeff_waddr),
    .wdata (coeff_data),
    .raddr (k_q),
    .rdata (coeff_rd)
  );

  assign x_k    = x_q[k_q];
  assign prod   = $signed({{32{coeff_rd[31]}}, coeff_rd}) * $signed({{32{x_k[31]}}, x_k});
  assign n_req  = eff_taps(tap_count, MAX_TAPS);
  // The tap count is captured only by the first write of a load.
  assign n_load = (wptr_q == '0) ? n_req : n_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wptr_d      = wptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    complete_d  = complete_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    overrun_d   = overrun_q;
    coeff_we    = 1'b0;
    coeff_waddr = '0;

    unique case (state_q)
      S_LOAD: begin
        if (coeff_data_valid) begin
          coeff_we    = 1'b1;
          coeff_waddr = IDX_W'(wptr_q);
          n_d         = n_load;
          wptr_d      = wptr_q + CNT_W'(1);
          if (wptr_q + CNT_W'(1) == n_load) begin
            complete_d = 1'b1;
            state_d    = S_READY;
          end
        end
      end
      S_READY: begin
        if (coeff_data_valid) begin
          // Reload takes priority over a simultaneous sample.
          coeff_we    = 1'b1;
          coeff_waddr = '0;
          n_d         = n_req;
          wptr_d      = CNT_W'(1);
          x_d         = '{default: '0};
          complete_d  = (n_req == CNT_W'(1));
          state_d     = (n_req == CNT_W'(1)) ? S_READY : S_LOAD;
          if (x_data_valid) overrun_d = 1'b1;
        end else if (x_data_valid) begin
          if (compute) begin
            x_d[0] = x_data;
            for (int i = 1; i < int'(MAX_TAPS); i++) x_d[i] = x_q[i-1];
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-64){prod[63]}}, prod};
        k_d   = k_q + IDX_W'(1);
        if (k_q == IDX_W'(n_q - CNT_W'(1))) state_d = S_OUT;
        if (x_data_valid) overrun_d = 1'b1;
      end
      S_OUT: begin
        valid_d = 1'b1;
        data_d  = sat32(acc_q >>> FRAC_BITS);
        state_d = S_READY;
        if (x_data_valid) overrun_d = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase

    busy_d = (state_d == S_MAC) || (state_d == S_OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_LOAD;
      n_q        <= CNT_W'(1);
      wptr_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      x_q        <= '{default: '0};
      complete_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wptr_q     <= wptr_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      complete_q <= complete_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign coefficient_loading_complete = complete_q;
  assign output_data_valid            = valid_q;
  assign output_data                  = data_q;
  assign busy                         = busy_q;
  assign overrun                      = overrun_q;

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Directed bench for fir_mac_datapath; a FRAC_BITS=2 copy shares the inputs.
module tb_fir_mac_datapath;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] tap_count;
  logic [31:0] coeff_data;
  logic        coeff_data_valid;
  logic [31:0] x_data;
  logic        x_data_valid;
  logic        compute;

  logic        complete, output_data_valid, busy, overrun;
  logic [31:0] output_data;
  logic        f_complete, f_valid, f_busy, f_overrun;
  logic [31:0] f_output_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_mac_datapath dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .tap_count                    (tap_count),
    .coeff_data                   (coeff_data),
    .coeff_data_valid             (coeff_data_valid),
    .x_data                       (x_data),
    .x_data_valid                 (x_data_valid),
    .compute                      (compute),
    .coefficient_loading_complete (complete),
    .output_data_valid            (output_data_valid),
    .output_data                  (output_data),
    .busy                         (busy),
    .overrun                      (overrun)
  );

  fir_mac_datapath #(.FRAC_BITS(2)) dut_frac (
    .clk                          (clk),
    .rstn                         (rstn),
    .tap_count                    (tap_count),
    .coeff_data                   (coeff_data),
    .coeff_data_valid             (coeff_data_valid),
    .x_data                       (x_data),
    .x_data_valid                 (x_data_valid),
    .compute                      (compute),
    .coefficient_loading_complete (f_complete),
    .output_data_valid            (f_valid),
    .output_data                  (f_output_data),
    .busy                         (f_busy),
    .overrun                      (f_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coeff(input logic [31:0] tc, input logic [31:0] c);
    tap_count        = tc;
    coeff_data       = c;
    coeff_data_valid = 1'b1;
    step();
    coeff_data_valid = 1'b0;
  endtask

  // Accept one sample, optionally inject a stray strobe mid-MAC, and wait for the result.
  task automatic send(input logic [31:0] x, input bit inject,
                      output logic [31:0] res, output logic [31:0] fres,
                      output int lat, output int bc);
    bit got;
    x_data       = x;
    x_data_valid = 1'b1;
    compute      = 1'b1;
    step();
    x_data_valid = 1'b0;
    compute      = 1'b0;
    lat = 0; bc = 0; got = 1'b0; res = '0; fres = '0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (output_data_valid) begin
        got  = 1'b1;
        res  = output_data;
        fres = f_output_data;
        break;
      end
      if (inject && i == 1) begin
        x_data       = 32'd100;
        x_data_valid = 1'b1;
      end else begin
        x_data_valid = 1'b0;
      end
      step();
      lat++;
    end
    x_data_valid = 1'b0;
    if (!got) check("result_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, fres;
    int lat, bc, vcount;

    rstn = 1'b0; tap_count = '0; coeff_data = '0; coeff_data_valid = 1'b0;
    x_data = '0; x_data_valid = 1'b0; compute = 1'b0;
    step(); step();
    check("rst_valid", 32'(output_data_valid), 32'd0);
    check("rst_data", output_data, 32'd0);
    check("rst_complete", 32'(complete), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;

    // Sample during load is ignored without flagging overrun
    x_data = 32'd77; x_data_valid = 1'b1; compute = 1'b1;
    step();
    x_data_valid = 1'b0; compute = 1'b0;
    check("load_x_busy", 32'(busy), 32'd0);
    check("load_x_overrun", 32'(overrun), 32'd0);

    // N latched on first write; the later tap_count=2 must not finish the load early
    wr_coeff(32'd4, 32'd1);
    wr_coeff(32'd2, 32'd2);
    check("latch_n", 32'(complete), 32'd0);
    wr_coeff(32'd4, 32'd3);
    check("complete_after3", 32'(complete), 32'd0);
    wr_coeff(32'd4, 32'd4);
    check("complete_after4", 32'(complete), 32'd1);

    // Impulse response and latency
    send(32'd1, 1'b0, res, fres, lat, bc);
    check("imp0", res, 32'd1);
    check("latency_n4", 32'(lat), 32'd5);
    check("busy_cycles_n4", 32'(bc), 32'd5);
    step();
    check("valid_one_cycle", 32'(output_data_valid), 32'd0);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("imp1", res, 32'd2);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("imp2", res, 32'd3);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("imp3", res, 32'd4);

    // Stray sample during MAC: dropped, overrun set, delay line untouched
    send(32'd5, 1'b1, res, fres, lat, bc);
    check("ovr_mac_result", res, 32'd5);
    check("ovr_mac_flag", 32'(overrun), 32'd1);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("ovr_mac_shift", res, 32'd10);
    send(32'd9, 1'b0, res, fres, lat, bc);  check("mix", res, 32'd24);

    // Reload in READY with N=2: delay line cleared
    wr_coeff(32'd2, 32'd7);
    check("reload_complete_drop", 32'(complete), 32'd0);
    wr_coeff(32'd2, 32'hFFFF_FFFD);
    check("reload_complete", 32'(complete), 32'd1);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("reload_cleared", res, 32'd0);
    send(32'd1, 1'b0, res, fres, lat, bc);  check("reload_imp0", res, 32'd7);
    send(32'd0, 1'b0, res, fres, lat, bc);  check("reload_imp1", res, 32'hFFFF_FFFD);

    // tap_count=0 clamps to one tap
    rstn = 1'b0; step(); rstn = 1'b1;
    check("rst2_overrun", 32'(overrun), 32'd0);
    wr_coeff(32'd0, 32'd3);
    check("n0_complete", 32'(complete), 32'd1);
    send(32'd5, 1'b0, res, fres, lat, bc);
    check("n1_result", res, 32'd15);
    check("latency_n1", 32'(lat), 32'd2);

    // Sample without compute in READY
    x_data = 32'd8; x_data_valid = 1'b1; compute = 1'b0;
    step();
    x_data_valid = 1'b0;
    check("nocomp_busy", 32'(busy), 32'd0);
    check("nocomp_overrun", 32'(overrun), 32'd1);

    // Saturation (N=1 reload goes straight back to READY)
    wr_coeff(32'd1, 32'h7FFF_FFFF);
    check("n1_reload_complete", 32'(complete), 32'd1);
    send(32'h7FFF_FFFF, 1'b0, res, fres, lat, bc);  check("sat_pos", res, 32'h7FFF_FFFF);
    send(32'h8000_0000, 1'b0, res, fres, lat, bc);  check("sat_neg", res, 32'h8000_0000);
    wr_coeff(32'd1, 32'd6);
    send(32'hFFFF_FFFF, 1'b0, res, fres, lat, bc);
    check("neg_frac0", res, 32'hFFFF_FFFA);
    check("neg_frac2", fres, 32'hFFFF_FFFE);

    // tap_count=20 clamps to 16; a 17th write starts a reload
    for (int i = 0; i < 16; i++) begin
      wr_coeff(32'd20, 32'd1);
      if (i == 14) check("clamp_after15", 32'(complete), 32'd0);
    end
    check("clamp_after16", 32'(complete), 32'd1);
    wr_coeff(32'd20, 32'd1);
    check("clamp_17th_reload", 32'(complete), 32'd0);

    // Reset mid-MAC at k=2 of N=4
    rstn = 1'b0; step(); rstn = 1'b1;
    wr_coeff(32'd4, 32'd1); wr_coeff(32'd4, 32'd2);
    wr_coeff(32'd4, 32'd3); wr_coeff(32'd4, 32'd4);
    send(32'd2, 1'b0, res, fres, lat, bc);  check("pre_rst_result", res, 32'd2);
    x_data = 32'd3; x_data_valid = 1'b1; compute = 1'b1;
    step();
    x_data_valid = 1'b0; compute = 1'b0;
    step(); step();
    check("mid_mac_busy", 32'(busy), 32'd1);
    rstn = 1'b0; step(); rstn = 1'b1;
    check("midrst_valid", 32'(output_data_valid), 32'd0);
    check("midrst_data", output_data, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_complete", 32'(complete), 32'd0);
    vcount = 0;
    repeat (8) begin
      step();
      if (output_data_valid) vcount++;
    end
    check("midrst_no_strobe", 32'(vcount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
